fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode; decode feeds immediate generation.
- Holds the 64-bit PC and issues word requests to instruction memory over a valid/ready port.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents {instruc, pc} to decode over a valid/ready handshake; supports branch redirect with flush.

---
 rtl/fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage feeding decode.
//
// Holds the 64-bit fetch PC and issues one word request at a time to
// instruction memory. Each returned instruction is queued with the PC it was
// fetched from, and the queue head is presented to decode. A branch redirect
// flushes the queue and restarts fetch at the new (word-aligned) PC. A
// response that is still in flight when the redirect arrives is discarded.
//
// Parameters
//   RESET_PC       PC loaded on reset
//   QUEUE_DEPTH    instruction queue entries (power of 2, >= 2)
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   imem_req_valid/addr/ready  fetch request (addr[1:0] always 0)
//   imem_rsp_valid/data        fetch response, one per accepted request
//   redirect_valid/pc          branch/jump redirect with flush
//   id_valid/instruc/pc/ready  decode handshake
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_fetched  count of instructions pushed into the queue
//   perf_dropped  count of responses discarded because of a redirect
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instruc,
    output logic [63:0] id_pc,
    input  logic        id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int          PTR_W = $clog2(QUEUE_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t             r_state;
    // Low during reset and until the first clock edge after it, so that no
    // request is presented while reset is still asserted.
    logic               r_run;
    logic [63:0]        r_pc;
    // PC of the outstanding request; this, not r_pc, tags the queued entry.
    logic [63:0]        r_req_pc;
    logic [31:0]        r_q_instr [QUEUE_DEPTH];
    logic [63:0]        r_q_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_not_full;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_push;
    logic               w_drop;
    logic               w_id_valid;
    logic               w_pop;

    // Only one request is ever outstanding, so a free slot at issue time
    // guarantees room for its response.
    assign w_not_full  = (r_count < CNT_W'(QUEUE_DEPTH));
    assign w_req_valid = r_run && (r_state == S_FETCH) && w_not_full && !redirect_valid;
    assign w_req_fire  = w_req_valid && imem_req_ready;

    // A response is queued only in WAIT with no redirect in the same cycle;
    // otherwise (DROP, or WAIT hit by a redirect) it is thrown away.
    assign w_push = imem_rsp_valid && (r_state == S_WAIT) && !redirect_valid;
    assign w_drop = imem_rsp_valid &&
                    ((r_state == S_DROP) || ((r_state == S_WAIT) && redirect_valid));

    assign w_id_valid = (r_count != '0);
    assign w_pop      = w_id_valid && id_ready && !redirect_valid;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = {r_pc[63:2], 2'b00};
    assign id_valid       = w_id_valid;
    assign id_instruc     = w_id_valid ? r_q_instr[r_rd_ptr] : NOP;
    assign id_pc          = w_id_valid ? r_q_pc[r_rd_ptr]    : 64'h0;

    // Control: state, PC, queue pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_run    <= 1'b0;
            r_pc     <= RESET_PC & ~64'h3;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_pc     <= redirect_pc & ~64'h3;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                // An in-flight request must still have its response absorbed
                // before fetching again, unless it arrives right now.
                case (r_state)
                    S_WAIT, S_DROP: r_state <= imem_rsp_valid ? S_FETCH : S_DROP;
                    default:        r_state <= S_FETCH;
                endcase
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (w_req_fire) begin
                            r_pc    <= r_pc + 64'd4;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT, S_DROP: begin
                        if (imem_rsp_valid) begin
                            r_state <= S_FETCH;
                        end
                    end
                    default: r_state <= S_FETCH;
                endcase

                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // Data: request tag and queue storage need no reset; empty-queue outputs
    // are forced to NOP/0 by the output muxes.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_req_pc <= r_pc;
        end
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rsp_data;
            r_q_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_drop) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A behavioural memory answers each accepted request after a configurable
// latency with a value derived from the address. The reference model tracks
// only the program-order PC stream: the next expected request address and
// the next expected PC seen by decode, both restarted by every redirect.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instruc;
    logic [63:0] id_pc;
    logic        id_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC    (64'h0),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instruc     (id_instruc),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory model state.
    logic        mem_pend;
    logic [63:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;
    bit          mem_rand_lat;
    int          rsp_count;

    // Per-cycle samples taken between the falling edge and the next rise.
    logic        s_req_v, s_req_rdy, s_hs, s_rsp_v, s_id_v, s_id_rdy, s_redir, s_pend_before;
    logic [63:0] s_req_a, s_id_pc, s_rsp_a, s_redir_pc;
    logic [31:0] s_id_i;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        if (a == 64'h0) return 32'h00A00093;
        if (a == 64'h4) return 32'h00100113;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0000_0003;
    endfunction

    // One clock cycle: present memory response, sample, clock, update memory.
    task automatic cycle();
        int lat;
        @(negedge clk);
        imem_rsp_valid = mem_pend && (mem_cnt == 0);
        imem_rsp_data  = mem_pend ? instr_of(mem_addr) : 32'hDEAD_BEEF;
        #1;
        s_req_v       = imem_req_valid;
        s_req_a       = imem_req_addr;
        s_req_rdy     = imem_req_ready;
        s_hs          = imem_req_valid && imem_req_ready;
        s_rsp_v       = imem_rsp_valid;
        s_rsp_a       = mem_addr;
        s_id_v        = id_valid;
        s_id_i        = id_instruc;
        s_id_pc       = id_pc;
        s_id_rdy      = id_ready;
        s_redir       = redirect_valid;
        s_redir_pc    = redirect_pc;
        s_pend_before = mem_pend;
        @(posedge clk);
        #1;
        if (s_rsp_v) begin
            mem_pend = 1'b0;
            rsp_count++;
        end else if (mem_pend) begin
            mem_cnt--;
        end
        if (s_hs) begin
            lat      = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
            mem_pend = 1'b1;
            mem_addr = s_req_a;
            mem_cnt  = lat - 1;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b0;
        mem_pend       = 1'b0;
        mem_cnt        = 0;
        mem_addr       = 64'h0;
        mem_lat        = 1;
        mem_rand_lat   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        rsp_count = 0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b1;
        mem_pend       = 1'b0;
        #3;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
        vectors++; if (id_instruc !== NOP) begin miscompares++; $display("FAIL rst_id_instruc: got %h expected %h", id_instruc, NOP); end
        vectors++; if (id_pc !== 64'h0) begin miscompares++; $display("FAIL rst_id_pc: got %h expected 0", id_pc); end
        do_reset();
        cycle();
        vectors++; if (s_req_v !== 1'b0) begin miscompares++; $display("FAIL rst_first_cycle_req: got %b expected 0", s_req_v); end
        cycle();
        vectors++; if (s_req_v !== 1'b1 || s_req_a !== 64'h0) begin miscompares++; $display("FAIL rst_first_req: got v=%b addr=%h expected v=1 addr=0", s_req_v, s_req_a); end
    endtask

    task automatic test_basic();
        logic [63:0] hs_q[$];
        logic [63:0] pc_q[$];
        logic [31:0] in_q[$];
        logic        prev_rsp;
        logic [63:0] prev_rsp_a;
        do_reset();
        id_ready = 1'b1;
        prev_rsp = 1'b0;
        prev_rsp_a = 64'h0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_hs) hs_q.push_back(s_req_a);
            if (s_id_v && s_id_rdy) begin
                pc_q.push_back(s_id_pc);
                in_q.push_back(s_id_i);
            end
            if (prev_rsp) begin
                vectors++;
                if (s_id_v !== 1'b1 || s_id_pc !== prev_rsp_a) begin
                    miscompares++;
                    $display("FAIL basic_latency: got v=%b pc=%h expected v=1 pc=%h", s_id_v, s_id_pc, prev_rsp_a);
                end
            end
            prev_rsp   = s_rsp_v;
            prev_rsp_a = s_rsp_a;
        end
        vectors++;
        if (hs_q.size() < 2 || pc_q.size() < 2) begin
            miscompares++;
            $display("FAIL basic_count: got %0d requests %0d entries expected at least 2 each", hs_q.size(), pc_q.size());
        end else begin
            if (hs_q[0] !== 64'h0 || hs_q[1] !== 64'h4) begin miscompares++; $display("FAIL basic_req_addr: got %h,%h expected 0,4", hs_q[0], hs_q[1]); end
            vectors++; if (pc_q[0] !== 64'h0 || in_q[0] !== 32'h00A00093) begin miscompares++; $display("FAIL basic_entry0: got %h@%h expected 00a00093@0", in_q[0], pc_q[0]); end
            vectors++; if (pc_q[1] !== 64'h4 || in_q[1] !== 32'h00100113) begin miscompares++; $display("FAIL basic_entry1: got %h@%h expected 00100113@4", in_q[1], pc_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        int          n_hs;
        logic [63:0] pc_q[$];
        logic [63:0] hs_q[$];
        do_reset();
        n_hs = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (s_hs) n_hs++;
            if (i >= 8) begin
                vectors++;
                if (s_req_v !== 1'b0 || s_id_v !== 1'b1 || s_id_pc !== 64'h0 || s_id_i !== 32'h00A00093) begin
                    miscompares++;
                    $display("FAIL bp_hold: got req=%b v=%b %h@%h expected req=0 v=1 00a00093@0", s_req_v, s_id_v, s_id_i, s_id_pc);
                end
            end
        end
        vectors++; if (n_hs !== 2) begin miscompares++; $display("FAIL bp_buffered: got %0d requests expected 2", n_hs); end
        id_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (s_hs) hs_q.push_back(s_req_a);
            if (s_id_v && s_id_rdy) pc_q.push_back(s_id_pc);
        end
        vectors++;
        if (hs_q.size() < 1 || pc_q.size() < 3) begin
            miscompares++;
            $display("FAIL bp_resume: got %0d requests %0d entries expected >=1 and >=3", hs_q.size(), pc_q.size());
        end else if (hs_q[0] !== 64'h8 || pc_q[0] !== 64'h0 || pc_q[1] !== 64'h4 || pc_q[2] !== 64'h8) begin
            miscompares++;
            $display("FAIL bp_resume: got req %h pcs %h %h %h expected 8 / 0 4 8", hs_q[0], pc_q[0], pc_q[1], pc_q[2]);
        end
    endtask

    task automatic test_redirect_wait();
        bit          found;
        bit          stale_seen;
        logic [63:0] first_req;
        do_reset();
        mem_lat = 4;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_hs && s_req_a == 64'h4) found = 1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rw_setup: got timeout expected request at 4"); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        cycle();
        vectors++; if (s_req_v !== 1'b0) begin miscompares++; $display("FAIL rw_req_in_redirect: got %b expected 0", s_req_v); end
        redirect_valid = 1'b0;
        cycle();
        vectors++; if (s_id_v !== 1'b0 || s_id_i !== NOP || s_id_pc !== 64'h0) begin miscompares++; $display("FAIL rw_flush: got v=%b %h@%h expected v=0 NOP@0", s_id_v, s_id_i, s_id_pc); end
        found = 0; stale_seen = 0; first_req = 64'h0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (s_hs) begin
                found = 1; first_req = s_req_a;
            end else begin
                if (s_id_v) stale_seen = 1;
                cycle();
            end
        end
        vectors++; if (!found || first_req !== 64'h100) begin miscompares++; $display("FAIL rw_next_req: got found=%0d addr=%h expected addr=100", found, first_req); end
        vectors++; if (stale_seen) begin miscompares++; $display("FAIL rw_stale_push: got entry before new request expected none"); end
        id_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_id_v && s_id_rdy) begin
                found = 1;
                vectors++;
                if (s_id_pc !== 64'h100 || s_id_i !== instr_of(64'h100)) begin
                    miscompares++;
                    $display("FAIL rw_first_entry: got %h@%h expected %h@100", s_id_i, s_id_pc, instr_of(64'h100));
                end
            end
        end
        if (!found) begin vectors++; miscompares++; $display("FAIL rw_first_entry: got timeout expected entry"); end
    endtask

    // Continues from test_redirect_wait without reset so drop counts add up.
    task automatic test_redirect_same_cycle();
        bit found;
        mem_lat  = 2;
        id_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (s_hs) found = 1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rs_setup: got timeout expected request"); end
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        cycle();
        vectors++; if (s_rsp_v !== 1'b1 || s_req_v !== 1'b0) begin miscompares++; $display("FAIL rs_align: got rsp=%b req=%b expected rsp=1 req=0", s_rsp_v, s_req_v); end
        redirect_valid = 1'b0;
        cycle();
        vectors++; if (s_id_v !== 1'b0) begin miscompares++; $display("FAIL rs_flush: got v=%b expected 0", s_id_v); end
        vectors++; if (s_req_v !== 1'b1 || s_req_a !== 64'h200) begin miscompares++; $display("FAIL rs_next_req: got v=%b addr=%h expected v=1 addr=200", s_req_v, s_req_a); end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_id_v && s_id_rdy) begin
                found = 1;
                vectors++;
                if (s_id_pc !== 64'h200 || s_id_i !== instr_of(64'h200)) begin
                    miscompares++;
                    $display("FAIL rs_first_entry: got %h@%h expected %h@200", s_id_i, s_id_pc, instr_of(64'h200));
                end
            end
        end
        if (!found) begin vectors++; miscompares++; $display("FAIL rs_first_entry: got timeout expected entry"); end
`ifdef FETCH_PERF_EN
        vectors++; if (perf_dropped !== 32'd2) begin miscompares++; $display("FAIL perf_dropped: got %0d expected 2", perf_dropped); end
        vectors++; if (perf_fetched !== 32'(rsp_count - 2)) begin miscompares++; $display("FAIL perf_fetched: got %0d expected %0d", perf_fetched, rsp_count - 2); end
`endif
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        mem_lat = 6;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (s_hs && s_req_a == 64'h4) found = 1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL ar_setup: got timeout expected request at 4"); end
        #2;
        vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre_entry: got v=%b expected 1", id_valid); end
        reset = 1'b1;
        #1;
        vectors++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL ar_immediate: got v=%b req=%b expected 0 0", id_valid, imem_req_valid); end
        cycle();
        cycle();
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_rsp_v) found = 1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL ar_stale: got timeout expected stale response"); end
        cycle();
        vectors++; if (s_id_v !== 1'b0 || s_req_v !== 1'b1 || s_req_a !== 64'h0) begin miscompares++; $display("FAIL ar_ignore_stale: got v=%b req=%b addr=%h expected 0 1 0", s_id_v, s_req_v, s_req_a); end
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_id_v && s_id_rdy) begin
                found = 1;
                vectors++;
                if (s_id_pc !== 64'h0 || s_id_i !== instr_of(64'h0)) begin
                    miscompares++;
                    $display("FAIL ar_restart: got %h@%h expected %h@0", s_id_i, s_id_pc, instr_of(64'h0));
                end
            end
        end
        if (!found) begin vectors++; miscompares++; $display("FAIL ar_restart: got timeout expected entry"); end
    endtask

    task automatic test_random();
        logic [63:0] exp_req, exp_cons;
        logic        prev_redir, prev_hold;
        logic [31:0] prev_i;
        logic [63:0] prev_pc;
        int          r;
        do_reset();
        mem_rand_lat = 1'b1;
        exp_req = 64'h0; exp_cons = 64'h0;
        prev_redir = 1'b0; prev_hold = 1'b0; prev_i = 32'h0; prev_pc = 64'h0;
        for (int i = 0; i < 2000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 4) < 3);
            r              = int'($urandom_range(0, 99));
            redirect_valid = (r < 3);
            redirect_pc    = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFF9 : {$urandom, $urandom};
            cycle();
            if (s_redir) begin
                vectors++; if (s_req_v !== 1'b0) begin miscompares++; $display("FAIL rnd_req_suppress: got %b expected 0", s_req_v); end
            end
            if (s_hs) begin
                vectors++; if (s_pend_before || s_req_a !== exp_req) begin miscompares++; $display("FAIL rnd_req: got addr=%h outstanding=%b expected addr=%h outstanding=0", s_req_a, s_pend_before, exp_req); end
                exp_req = exp_req + 64'd4;
            end
            if (!s_id_v) begin
                vectors++; if (s_id_i !== NOP || s_id_pc !== 64'h0) begin miscompares++; $display("FAIL rnd_empty: got %h@%h expected NOP@0", s_id_i, s_id_pc); end
            end
            if (prev_redir) begin
                vectors++; if (s_id_v !== 1'b0) begin miscompares++; $display("FAIL rnd_flush: got v=%b expected 0", s_id_v); end
            end
            if (prev_hold) begin
                vectors++; if (s_id_v !== 1'b1 || s_id_i !== prev_i || s_id_pc !== prev_pc) begin miscompares++; $display("FAIL rnd_stable: got v=%b %h@%h expected v=1 %h@%h", s_id_v, s_id_i, s_id_pc, prev_i, prev_pc); end
            end
            if (s_id_v && s_id_rdy && !s_redir) begin
                vectors++; if (s_id_pc !== exp_cons || s_id_i !== instr_of(exp_cons)) begin miscompares++; $display("FAIL rnd_entry: got %h@%h expected %h@%h", s_id_i, s_id_pc, instr_of(exp_cons), exp_cons); end
                exp_cons = exp_cons + 64'd4;
            end
            if (s_redir) begin
                exp_req  = s_redir_pc & ~64'h3;
                exp_cons = s_redir_pc & ~64'h3;
            end
            prev_redir = s_redir;
            prev_hold  = s_id_v && !s_id_rdy && !s_redir;
            prev_i     = s_id_i;
            prev_pc    = s_id_pc;
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
